// File: rtl/regfile_pkg.sv
// Shared widths and the write-command record for the register-file access controller.
package regfile_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int DATA_W     = 8;
    localparam int NUM_REGS   = 8;
    // Wide enough for a count of up to 8 buffered commands plus the issue stage.
    localparam int CNT_W      = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wr_cmd_t;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Write-command and read-request channels between a requester and regfile_access_ctrl.
interface regfile_access_ctrl_if;
    import regfile_pkg::*;

    // Write channel: a command transfers on a rising clk edge where wr_valid and wr_ready
    // are both high. Read channel: rd_valid is never back-pressured; the answer appears
    // on rd_data with rd_data_valid high for exactly the following cycle.
    logic                  wr_valid;
    logic                  wr_ready;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  rd_valid;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  rd_data_valid;
    logic [DATA_W-1:0]     rd_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        input  wr_ready, rd_data_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        output wr_ready, rd_data_valid, rd_data
    );

endinterface

// File: rtl/regfile_cmd_fifo.sv
// In-order write-command FIFO; also presents its live entries oldest-first for forwarding.
module regfile_cmd_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wr_cmd_t          push_cmd,
    input  logic             pop,
    output wr_cmd_t          head_cmd,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [DEPTH-1:0] entry_valid,
    output wr_cmd_t          entry_cmd [DEPTH]
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wr_cmd_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_cmd = mem[rd_ptr];

    // Storage carries no reset; only count-qualified slots are ever observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_cmd;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Index 0 is the oldest entry; a slot is valid only below the live count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_cmd[i]   = mem[rd_ptr + PTR_W'(i)];
            entry_valid[i] = (CNT_W'(i) < count);
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Buffers register writes, issues one per cycle to the register file, and answers reads
// with write-before-read forwarding from in-flight commands.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    regfile_access_ctrl_if.slave  bus,
    output logic [REG_ADDR_W-1:0] rf_writereg,
    output logic [DATA_W-1:0]     rf_writedata,
    output logic                  rf_writeenable,
    output logic [REG_ADDR_W-1:0] rf_readreg,
    input  logic [DATA_W-1:0]     rf_regout,
    output logic [CNT_W-1:0]      pending
);

    wr_cmd_t          push_cmd;
    wr_cmd_t          head_cmd;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [DEPTH-1:0] entry_valid;
    wr_cmd_t          entry_cmd [DEPTH];
    logic [DATA_W-1:0] fwd_data;
    logic              rd_data_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    // Ready depends only on the current count, so a same-edge pop never unblocks a full FIFO.
    assign bus.wr_ready = !fifo_full && reset_n;
    assign push         = bus.wr_valid && bus.wr_ready;
    assign push_cmd     = '{addr: bus.wr_addr, data: bus.wr_data};

    regfile_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset_n),
        .push        (push),
        .push_cmd    (push_cmd),
        .pop         (!fifo_empty),
        .head_cmd    (head_cmd),
        .count       (fifo_count),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_valid (entry_valid),
        .entry_cmd   (entry_cmd)
    );

    // Issue stage: whatever sits at the FIFO head drains into it on every edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_writeenable <= 1'b0;
            rf_writereg    <= '0;
            rf_writedata   <= '0;
        end else begin
            rf_writeenable <= !fifo_empty;
            if (!fifo_empty) begin
                rf_writereg  <= head_cmd.addr;
                rf_writedata <= head_cmd.data;
            end
        end
    end

    assign rf_readreg = bus.rd_addr;

    // Lowest priority is assigned first; each later override is a younger write.
    always_comb begin
        fwd_data = rf_regout;
        if (rf_writeenable && (rf_writereg == bus.rd_addr)) begin
            fwd_data = rf_writedata;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_cmd[i].addr == bus.rd_addr)) begin
                fwd_data = entry_cmd[i].data;
            end
        end
        if (push && (bus.wr_addr == bus.rd_addr)) begin
            fwd_data = bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_valid_q <= 1'b0;
            rd_data_q       <= '0;
        end else begin
            rd_data_valid_q <= bus.rd_valid;
            if (bus.rd_valid) begin
                rd_data_q <= fwd_data;
            end
        end
    end

    assign bus.rd_data_valid = rd_data_valid_q;
    assign bus.rd_data       = rd_data_q;
    assign pending           = fifo_count + CNT_W'(rf_writeenable);

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Randomised and directed bench for regfile_access_ctrl against a queue-based model.
module tb_regfile_access_ctrl;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  regfile_access_ctrl_if bus();
  logic [2:0] rf_writereg;
  logic [7:0] rf_writedata;
  logic       rf_writeenable;
  logic [2:0] rf_readreg;
  logic [7:0] rf_regout;
  logic [3:0] pending;

  regfile_access_ctrl #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .rf_writereg    (rf_writereg),
    .rf_writedata   (rf_writedata),
    .rf_writeenable (rf_writeenable),
    .rf_readreg     (rf_readreg),
    .rf_regout      (rf_regout),
    .pending        (pending)
  );

  // ---------------- model state / scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [10:0] exp_q[$];      // buffered commands {addr, data}, oldest first
  logic [10:0] issued_q[$];   // commands seen on the register-file write port
  logic        iss_v;
  logic [2:0]  iss_a;
  logic [7:0]  iss_d;
  logic        exp_rdv;
  logic [7:0]  exp_rdd;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    iss_v = 1'b0;
    iss_a = '0;
    iss_d = '0;
    exp_rdv = 1'b0;
    exp_rdd = '0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic wv, input logic [2:0] wa, input logic [7:0] wd,
                       input logic rv, input logic [2:0] ra, input logic [7:0] regout);
    bus.wr_valid = wv;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd_valid = rv;
    bus.rd_addr  = ra;
    rf_regout    = regout;
  endtask

  task automatic drive_idle();
    drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'($urandom_range(0, 255)));
  endtask

  // One clock: check combinational outputs, advance the model, then check registered outputs.
  task automatic step();
    logic       acc;
    logic [7:0] fwd;
    logic       found;
    #1;
    chk("wr_ready", bus.wr_ready, exp_q.size() < DEPTH);
    chk("rf_readreg", rf_readreg, bus.rd_addr);
    acc = bus.wr_valid && (exp_q.size() < DEPTH);
    // Read answer: same-edge write, else youngest buffered, else issue stage, else RF.
    found = 1'b0;
    fwd = rf_regout;
    if (acc && bus.wr_addr == bus.rd_addr) begin
      fwd = bus.wr_data;
      found = 1'b1;
    end
    for (int i = exp_q.size() - 1; i >= 0 && !found; i--) begin
      if (exp_q[i][10:8] == bus.rd_addr) begin
        fwd = exp_q[i][7:0];
        found = 1'b1;
      end
    end
    if (!found && iss_v && iss_a == bus.rd_addr) fwd = iss_d;
    if (exp_q.size() > 0) begin
      {iss_a, iss_d} = exp_q.pop_front();
      iss_v = 1'b1;
    end else begin
      iss_v = 1'b0;
    end
    if (acc) exp_q.push_back({bus.wr_addr, bus.wr_data});
    exp_rdv = bus.rd_valid;
    if (bus.rd_valid) exp_rdd = fwd;
    @(posedge clk);
    #1;
    chk("rf_writeenable", rf_writeenable, iss_v);
    chk("rf_writereg", rf_writereg, iss_a);
    chk("rf_writedata", rf_writedata, iss_d);
    chk("rd_data_valid", bus.rd_data_valid, exp_rdv);
    chk("rd_data", bus.rd_data, exp_rdd);
    chk("pending", pending, exp_q.size() + int'(iss_v));
    if (rf_writeenable) issued_q.push_back({rf_writereg, rf_writedata});
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_we"}, rf_writeenable, 0);
    chk({tag, "_wreg"}, rf_writereg, 0);
    chk({tag, "_wdata"}, rf_writedata, 0);
    chk({tag, "_rdv"}, bus.rd_data_valid, 0);
    chk({tag, "_rdd"}, bus.rd_data, 0);
    chk({tag, "_pending"}, pending, 0);
    chk({tag, "_wr_ready"}, bus.wr_ready, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    drive(1'b1, 3'd7, 8'hFF, 1'b1, 3'd7, 8'h11);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    drive_idle();
    #1;
    chk("ready_after_reset", bus.wr_ready, 1);

    // Basic issue: write (4, 45), enable appears after the second edge.
    drive(1'b1, 3'd4, 8'd45, 1'b0, 3'd0, 8'h00);
    step();
    chk("basic_we_edge1", rf_writeenable, 0);
    drive_idle();
    step();
    chk("basic_we_edge2", rf_writeenable, 1);
    chk("basic_reg", rf_writereg, 4);
    chk("basic_data", rf_writedata, 45);
    step();
    chk("basic_we_edge3", rf_writeenable, 0);

    // Back-to-back writes addr 0..4 / data 10..14 must issue in order.
    issued_q.delete();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'(i), 8'(10 + i), 1'b0, 3'd0, 8'($urandom_range(0, 255)));
      step();
    end
    drive_idle();
    repeat (3) step();
    chk("b2b_count", issued_q.size(), 5);
    for (int i = 0; i < 5 && i < issued_q.size(); i++) begin
      chk("b2b_order", issued_q[i], {3'(i), 8'(10 + i)});
    end

    // Forwarding: reg 2 written 10 then 20; read must return 20, not RF data.
    drive(1'b1, 3'd2, 8'd10, 1'b0, 3'd0, 8'h33);
    step();
    drive(1'b1, 3'd2, 8'd20, 1'b0, 3'd0, 8'h33);
    step();
    drive(1'b0, 3'd0, 8'd0, 1'b1, 3'd2, 8'h33);
    step();
    chk("fwd_rdv", bus.rd_data_valid, 1);
    chk("fwd_rdd", bus.rd_data, 20);

    // Same-edge write and read, then a plain read from the register file.
    drive(1'b1, 3'd1, 8'd88, 1'b1, 3'd1, 8'h00);
    step();
    chk("same_edge_rdd", bus.rd_data, 88);
    drive_idle();
    repeat (3) step();
    drive(1'b0, 3'd0, 8'd0, 1'b1, 3'd3, 8'h5A);
    step();
    chk("rf_read_rdd", bus.rd_data, 8'h5A);
    drive_idle();
    step();
    chk("rdv_drop", bus.rd_data_valid, 0);
    chk("rdd_hold", bus.rd_data, 8'h5A);

    // Wrap-around: repeated writes to reg 5 interleaved with reads of it.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i % 3 == 0) ? 3'd6 : 3'd5, 8'(100 + i), i[0], 3'd5, 8'($urandom_range(0, 255)));
      step();
    end
    drive(1'b0, 3'd0, 8'd0, 1'b1, 3'd5, 8'hC3);
    step();
    drive(1'b0, 3'd0, 8'd0, 1'b1, 3'd5, 8'hC3);
    step();
    chk("wrap_stale_rdd", bus.rd_data, 8'hC3);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      step();
    end

    // Reset mid-operation: asynchronous, between edges, with writes in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'(i), 8'(50 + i), 1'b1, 3'(i), 8'h00);
      step();
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_we", rf_writeenable, 0);
      chk("midrst_pending", pending, 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive_idle();
    #1;
    chk("ready_after_midrst", bus.wr_ready, 1);
    repeat (3) step();
    chk("midrst_drained_pending", pending, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
